// File: rtl/i2c_config_target.sv
// I2C target exposing a byte-addressed register file: one sub-address byte sets
// an auto-incrementing pointer, then data bytes are written or read from it.
module i2c_config_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] o_dbg_state
);

  // IDLE encodes as 0 so the debug port reads 0 whenever the target is idle.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_SUB       = 4'd3,
    S_SUB_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

  state_t      r_state;
  logic        r_scl_s1, r_scl_s2, r_scl_prev;
  logic        r_sda_s1, r_sda_s2, r_sda_prev;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_ptr;
  logic        r_rw;
  logic        r_ack_bit;
  logic        r_sda_low;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_busy;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;

  assign I2C_SDAT = r_sda_low ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history stage; bus events come only from these.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_s1   <= I2C_SCLK;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= I2C_SDAT;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
    end
  end

  assign w_scl_rise   = r_scl_s2 & ~r_scl_prev;
  assign w_scl_fall   = ~r_scl_s2 & r_scl_prev;
  assign w_start      = r_scl_s2 & r_scl_prev & ~r_sda_s2 & r_sda_prev;
  assign w_stop       = r_scl_s2 & r_scl_prev & r_sda_s2 & ~r_sda_prev;
  assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_ptr     <= 8'h00;
      r_rw      <= 1'b0;
      r_ack_bit <= 1'b1;
      r_sda_low <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
          end
          S_ADDR: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (w_addr_match) begin
                r_rw      <= r_shift[0];
                r_sda_low <= 1'b1;
                r_busy    <= 1'b1;
                r_state   <= S_ADDR_ACK;
              end else begin
                r_busy    <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_shift   <= rd_data;
                r_sda_low <= ~rd_data[7];
                r_state   <= S_RDATA;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= S_SUB;
              end
            end
          end
          S_SUB: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_ptr     <= r_shift;
              r_bit_cnt <= 4'd0;
              r_sda_low <= 1'b1;
              r_state   <= S_SUB_ACK;
            end
          end
          S_SUB_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_state   <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= r_shift;
              r_ptr     <= r_ptr + 8'd1;
              r_bit_cnt <= 4'd0;
              r_sda_low <= 1'b1;
              r_state   <= S_WDATA_ACK;
            end
          end
          S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_state   <= S_WDATA;
            end
          end
          S_RDATA: begin
            // Bit 7 is already on the bus; each later fall presents the next bit.
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_bit_cnt <= 4'd0;
                r_sda_low <= 1'b0;
                r_state   <= S_RDATA_ACK;
              end else if (r_bit_cnt != 4'd0) begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_low <= ~r_shift[6];
              end
            end
          end
          S_RDATA_ACK: begin
            // Pointer advances on the ACK rise so rd_data is settled by the fall.
            if (w_scl_rise) begin
              r_ack_bit <= r_sda_s2;
              if (!r_sda_s2) begin
                r_ptr <= r_ptr + 8'd1;
              end
            end else if (w_scl_fall) begin
              if (!r_ack_bit) begin
                r_shift   <= rd_data;
                r_sda_low <= ~rd_data[7];
                r_state   <= S_RDATA;
              end else begin
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end
          default: begin
            r_sda_low <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign rd_addr     = r_ptr;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_config_target.sv
// Bench for i2c_config_target: an I2C initiator model drives the bus, a register
// model predicts writes, read bytes and pointer, and a monitor scores wr_en strobes.
module tb_i2c_config_target;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  wire        sda_bus;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       busy;
  logic [3:0] dbg_state;

  logic [7:0]  mem [256];
  logic [7:0]  m_ptr;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  logic [7:0]  wq [$];
  logic        watch_drive = 1'b0;
  logic        dut_drove = 1'b0;
  int          total = 0;
  int          bad = 0;

  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign rd_data = mem[rd_addr];

  always #10 clk = ~clk;

  i2c_config_target #(.SLAVE_ADDR(7'h1A)) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .I2C_SCLK    (scl),
    .I2C_SDAT    (sda_bus),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops one expected (addr,data) pair.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, mon_e});
      end
    end
    if (watch_drive && !tb_sda_low && sda_bus === 1'b0) dut_drove = 1'b1;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    tb_sda_low = 1'b0; wait_q();
    scl = 1'b1;        wait_q();
    tb_sda_low = 1'b1; wait_q();
    scl = 1'b0;        wait_q();
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; wait_q();
    scl = 1'b1;        wait_q();
    tb_sda_low = 1'b0; wait_q();
    wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    tb_sda_low = ~b; wait_q();
    scl = 1'b1;      wait_q();
    sampled = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(ack_bit, s);
  endtask

  // Writes the bytes queued in wq starting at register 'sub'.
  task automatic do_write(input logic [7:0] sub);
    logic ack;
    logic [7:0] d;
    bus_start();
    send_byte(8'h34, ack); check("w_addr_ack", ack, 0);
    send_byte(sub, ack);   check("w_sub_ack", ack, 0);
    m_ptr = sub;
    while (wq.size() > 0) begin
      d = wq.pop_front();
      exp_q.push_back({m_ptr, d});
      mem[m_ptr] = d;
      m_ptr = m_ptr + 8'd1;
      send_byte(d, ack);
      check("w_data_ack", ack, 0);
    end
    bus_stop();
    check("w_q_drained", exp_q.size(), 0);
    check("w_ptr", rd_addr, m_ptr);
    check("w_busy", busy, 0);
  endtask

  task automatic do_read(input logic [7:0] sub, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    send_byte(8'h34, ack); check("r_waddr_ack", ack, 0);
    send_byte(sub, ack);   check("r_sub_ack", ack, 0);
    m_ptr = sub;
    bus_start();
    send_byte(8'h35, ack); check("r_raddr_ack", ack, 0);
    check("r_busy_mid", busy, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      check("r_byte", d, mem[m_ptr]);
      if (i < n - 1) m_ptr = m_ptr + 8'd1;
    end
    check("r_nack_idle", dbg_state, 0);
    check("r_nack_sda_released", sda_bus, 1);
    check("r_nack_busy", busy, 0);
    bus_stop();
    check("r_ptr", rd_addr, m_ptr);
  endtask

  task automatic do_mismatch(input logic [7:0] addr_byte, input int n);
    logic ack;
    watch_drive = 1'b1;
    dut_drove = 1'b0;
    bus_start();
    send_byte(addr_byte, ack); check("m_addr_nack", ack, 1);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom_range(0, 255)), ack);
      check("m_data_nack", ack, 1);
    end
    check("m_busy", busy, 0);
    bus_stop();
    watch_drive = 1'b0;
    check("m_no_drive", dut_drove, 0);
    check("m_ptr", rd_addr, m_ptr);
  endtask

  task automatic do_partial(input logic [7:0] sub);
    logic ack, s;
    bus_start();
    send_byte(8'h34, ack); check("p_addr_ack", ack, 0);
    send_byte(sub, ack);   check("p_sub_ack", ack, 0);
    m_ptr = sub;
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
    bus_stop();
    check("p_ptr", rd_addr, m_ptr);
    check("p_busy", busy, 0);
    check("p_idle", dbg_state, 0);
  endtask

  task automatic do_reset_in_ack();
    logic s;
    logic [7:0] a;
    a = 8'h34;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(a[i], s);
    tb_sda_low = 1'b0; wait_q();
    scl = 1'b1;        wait_q();
    check("x_ack_driven", sda_bus, 0);
    rst = 1'b1;
    #1;
    check("x_sda_released", sda_bus, 1);
    check("x_wr_en", wr_en, 0);
    check("x_busy", busy, 0);
    check("x_state", dbg_state, 0);
    check("x_ptr", rd_addr, 0);
    check("x_wr_addr", wr_addr, 0);
    check("x_wr_data", wr_data, 0);
    wait_q();
    scl = 1'b0; wait_q();
    rst = 1'b0;
    m_ptr = 8'h00;
    wait_q();
    bus_stop();
    check("x_post_idle", dbg_state, 0);
  endtask

  initial begin
    logic [7:0] sub, ab;
    int kind, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    m_ptr = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_ptr", rd_addr, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda_bus, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    wq.push_back(8'h4A);
    do_write(8'h0E);
    do_mismatch(8'h40, 2);
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_write(8'hFF);
    mem[8'h05] = 8'h5A;
    do_read(8'h05, 1);
    do_partial(8'h37);
    do_reset_in_ack();

    for (int t = 0; t < 18; t++) begin
      kind = $urandom_range(0, 3);
      sub = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFD, 8'hFF)) : 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      case (kind)
        0: begin
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
          do_write(sub);
        end
        1: do_read(sub, n);
        2: begin
          ab = 8'($urandom_range(0, 255));
          while (ab[7:1] == 7'h1A) ab = 8'($urandom_range(0, 255));
          do_mismatch(ab, n);
        end
        default: do_partial(sub);
      endcase
    end

    repeat (20) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
